// File: rtl/receive_switch_array.sv
// N-channel receive T/R protection switch controller with per-channel holdoff,
// MA timeout fault flags and a small register map on the system clock.
module receive_switch_array #(
  parameter int   N_CH        = 4,
  parameter int   CNT_W       = 16,
  parameter logic ON          = 1'b0,
  parameter logic OFF         = 1'b1,
  parameter int   REG_BASE    = 176,
  parameter int   HOLDOFF_DEF = 256,
  parameter int   TIMEOUT_CYC = 4000
) (
  input  logic            i_clock_10m,
  input  logic            i_reset,
  input  logic            i_wr_stb,
  input  logic [15:0]     i_addr,
  input  logic [31:0]     i_data,
  input  logic            i_sw_en,
  input  logic [7:0]      i_probe_mode,
  input  logic [N_CH-1:0] i_pre_gen,
  input  logic [N_CH-1:0] i_rf_ma,
  output logic [N_CH-1:0] o_receive_sw,
  output logic [N_CH-1:0] o_lo_ma,
  output logic [N_CH-1:0] o_busy,
  output logic [N_CH-1:0] o_fault
);

  typedef enum logic [2:0] {IDLE, TX, MA, HOLD, RX} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_RST  = CNT_W'(HOLDOFF_DEF);

  logic [N_CH-1:0]  r_genSync1, r_genSync2, r_genHist;
  logic [N_CH-1:0]  r_maSync1, r_maSync2, r_maHist;
  logic [N_CH-1:0]  r_sw, r_loEn, r_fault;
  logic [7:0]       r_modePrev;
  state_t           r_state   [N_CH];
  logic [CNT_W-1:0] r_cnt     [N_CH];
  logic [CNT_W-1:0] r_holdOff [N_CH];

  logic [N_CH-1:0]  w_genRise, w_maRise, w_maFall;
  logic [N_CH-1:0]  w_holdWr, w_loWr, w_faultClr;
  logic [15:0]      w_regOffset;
  logic             w_modeChange, w_gated, w_forcedOn;
  logic             w_unused;

  assign w_genRise    = r_genSync2 & ~r_genHist;
  assign w_maRise     = r_maSync2 & ~r_maHist;
  assign w_maFall     = ~r_maSync2 & r_maHist;
  assign w_modeChange = (i_probe_mode != r_modePrev);
  assign w_gated      = (i_probe_mode == 8'd1) || (i_probe_mode == 8'd3);
  assign w_forcedOn   = (i_probe_mode == 8'd4) || (i_probe_mode == 8'd5);
  assign w_regOffset  = i_addr - 16'(REG_BASE);
  assign w_unused     = ^i_data;

  // Offsets outside the populated channels decode to nothing.
  always_comb begin
    w_holdWr   = '0;
    w_loWr     = '0;
    w_faultClr = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_holdWr[i] = i_wr_stb && (w_regOffset == 16'(i));
      w_loWr[i]   = i_wr_stb && (w_regOffset == 16'(16 + i));
    end
    if (i_wr_stb && (w_regOffset == 16'd32))
      w_faultClr = i_data[N_CH-1:0];
  end

  always_ff @(posedge i_clock_10m) begin
    if (i_reset) begin
      r_genSync1 <= '0;
      r_genSync2 <= '0;
      r_genHist  <= '0;
      r_maSync1  <= '0;
      r_maSync2  <= '0;
      r_maHist   <= '0;
      r_sw       <= {N_CH{OFF}};
      r_loEn     <= '1;
      r_fault    <= '0;
      r_modePrev <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        r_state[ch]   <= IDLE;
        r_cnt[ch]     <= '0;
        r_holdOff[ch] <= HOLDOFF_RST;
      end
    end else begin
      r_genSync1 <= i_pre_gen;
      r_genSync2 <= r_genSync1;
      r_genHist  <= r_genSync2;
      r_maSync1  <= i_rf_ma;
      r_maSync2  <= r_maSync1;
      r_maHist   <= r_maSync2;
      r_modePrev <= i_probe_mode;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (w_holdWr[ch]) r_holdOff[ch] <= i_data[CNT_W-1:0];
        if (w_loWr[ch])   r_loEn[ch]    <= i_data[0];
        if (w_faultClr[ch]) r_fault[ch] <= 1'b0;
        // Disable, a mode change, or any ungated mode parks the FSM; a timeout set below beats a same-cycle clear.
        if (!i_sw_en || w_modeChange || !w_gated) begin
          r_state[ch] <= IDLE;
          r_cnt[ch]   <= '0;
          r_sw[ch]    <= (i_sw_en && !w_modeChange && w_forcedOn) ? ON : OFF;
        end else if (w_genRise[ch]) begin
          r_state[ch] <= TX;
          r_cnt[ch]   <= '0;
          r_sw[ch]    <= OFF;
        end else begin
          case (r_state[ch])
            IDLE: r_sw[ch] <= OFF;
            TX: begin
              r_sw[ch] <= OFF;
              if (w_maRise[ch]) begin
                r_state[ch] <= MA;
                r_cnt[ch]   <= '0;
              end else if (r_cnt[ch] == TIMEOUT_LAST) begin
                r_state[ch] <= HOLD;
                r_cnt[ch]   <= '0;
                r_fault[ch] <= 1'b1;
              end else begin
                r_cnt[ch] <= r_cnt[ch] + 1'b1;
              end
            end
            MA: begin
              r_sw[ch] <= OFF;
              if (w_maFall[ch]) begin
                r_state[ch] <= HOLD;
                r_cnt[ch]   <= '0;
              end
            end
            HOLD: begin
              if (r_cnt[ch] == r_holdOff[ch]) begin
                r_state[ch] <= RX;
                r_sw[ch]    <= ON;
              end else begin
                r_cnt[ch] <= r_cnt[ch] + 1'b1;
                r_sw[ch]  <= OFF;
              end
            end
            RX: r_sw[ch] <= ON;
            default: begin
              r_state[ch] <= IDLE;
              r_sw[ch]    <= OFF;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    o_busy = '0;
    for (int ch = 0; ch < N_CH; ch++)
      o_busy[ch] = (r_state[ch] == TX) || (r_state[ch] == MA) || (r_state[ch] == HOLD);
  end

  assign o_receive_sw = i_sw_en ? r_sw : {N_CH{OFF}};
  assign o_lo_ma      = ~r_loEn | ~r_sw;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_receive_switch_array.sv
// Scoreboard bench for receive_switch_array: directed stimulus queues expected
// output values per cycle, an independent monitor compares them after each edge.
module tb_receive_switch_array;

  localparam int SIG_SW    = 0;
  localparam int SIG_LO    = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_FAULT = 3;

  typedef struct {
    int          cyc;
    string       name;
    int          sig;
    logic [3:0]  mask;
    logic [3:0]  expVal;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wrStb;
  logic [15:0] addr;
  logic [31:0] data;
  logic        swEn;
  logic [7:0]  probeMode;
  logic [3:0]  preGen, rfMa;
  logic [3:0]  receiveSw, loMa, busy, fault;

  exp_t sbQueue[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  receive_switch_array #(
    .N_CH(4), .CNT_W(16), .REG_BASE(176), .HOLDOFF_DEF(256), .TIMEOUT_CYC(100)
  ) dut (
    .i_clock_10m (clock),
    .i_reset     (reset),
    .i_wr_stb    (wrStb),
    .i_addr      (addr),
    .i_data      (data),
    .i_sw_en     (swEn),
    .i_probe_mode(probeMode),
    .i_pre_gen   (preGen),
    .i_rf_ma     (rfMa),
    .o_receive_sw(receiveSw),
    .o_lo_ma     (loMa),
    .o_busy      (busy),
    .o_fault     (fault)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] sampleSig(input int sig);
    case (sig)
      SIG_SW:   return receiveSw;
      SIG_LO:   return loMa;
      SIG_BUSY: return busy;
      default:  return fault;
    endcase
  endfunction

  task automatic checkOutput(input int atCyc, input string name, input int sig,
                             input logic [3:0] mask, input logic [3:0] expVal);
    exp_t e;
    e.cyc = atCyc; e.name = name; e.sig = sig; e.mask = mask; e.expVal = expVal;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] gen, input logic [3:0] ma);
    preGen = gen;
    rfMa   = ma;
  endtask

  task automatic regWrite(input logic [15:0] a, input logic [31:0] d);
    wrStb = 1'b1; addr = a; data = d;
    @(negedge clock);
    wrStb = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor: count edges, then compare every expectation due on this cycle.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      begin
        int i;
        logic [3:0] act;
        i = 0;
        while (i < sbQueue.size()) begin
          if (sbQueue[i].cyc <= cyc) begin
            act = sampleSig(sbQueue[i].sig);
            checks++;
            if (sbQueue[i].cyc < cyc) begin
              failures++;
              $display("[TB] FAIL %s stale expectation for cyc=%0d at cyc=%0d", sbQueue[i].name, sbQueue[i].cyc, cyc);
            end else if ((act & sbQueue[i].mask) !== (sbQueue[i].expVal & sbQueue[i].mask)) begin
              failures++;
              $display("[TB] FAIL %s cyc=%0d actual=%b expected=%b mask=%b", sbQueue[i].name, cyc, act, sbQueue[i].expVal, sbQueue[i].mask);
            end
            sbQueue.delete(i);
          end else begin
            i++;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; wrStb = 1'b0; addr = '0; data = '0;
    swEn = 1'b1; probeMode = 8'd1; preGen = '0; rfMa = '0;
    checkOutput(2, "rstSw",    SIG_SW,    4'hF, 4'hF);
    checkOutput(2, "rstLo",    SIG_LO,    4'hF, 4'h0);
    checkOutput(2, "rstBusy",  SIG_BUSY,  4'hF, 4'h0);
    checkOutput(2, "rstFault", SIG_FAULT, 4'hF, 4'h0);
    waitUntil(3);
    reset = 1'b0;
    regWrite(16'd176, 32'd10);

    // ch0: GEN pulse then 20-cycle MA, holdoff 10
    waitUntil(5);
    checkOutput(7,  "genBusyPre",  SIG_BUSY, 4'h1, 4'h0);
    checkOutput(8,  "genBusy",     SIG_BUSY, 4'h1, 4'h1);
    checkOutput(8,  "genSwOff",    SIG_SW,   4'h1, 4'h1);
    checkOutput(41, "holdSwOff",   SIG_SW,   4'h1, 4'h1);
    checkOutput(42, "holdSwOn",    SIG_SW,   4'h1, 4'h0);
    checkOutput(41, "holdBusy",    SIG_BUSY, 4'h1, 4'h1);
    checkOutput(42, "rxBusy",      SIG_BUSY, 4'h1, 4'h0);
    checkOutput(41, "holdLo",      SIG_LO,   4'h1, 4'h0);
    checkOutput(42, "rxLo",        SIG_LO,   4'h1, 4'h1);
    applyStimulus(4'h1, 4'h0);
    waitUntil(7);  applyStimulus(4'h0, 4'h0);
    waitUntil(8);  applyStimulus(4'h0, 4'h1);
    waitUntil(28); applyStimulus(4'h0, 4'h0);

    // ch0: GEN from RX with no MA -> timeout fault, then clear
    waitUntil(45);
    checkOutput(47,  "rxSwOn",      SIG_SW,    4'h1, 4'h0);
    checkOutput(48,  "rxToTxOff",   SIG_SW,    4'h1, 4'h1);
    checkOutput(147, "faultPre",    SIG_FAULT, 4'h1, 4'h0);
    checkOutput(148, "faultSet",    SIG_FAULT, 4'h1, 4'h1);
    checkOutput(148, "faultBusy",   SIG_BUSY,  4'h1, 4'h1);
    checkOutput(158, "toHoldOff",   SIG_SW,    4'h1, 4'h1);
    checkOutput(159, "toHoldOn",    SIG_SW,    4'h1, 4'h0);
    checkOutput(164, "faultSticky", SIG_FAULT, 4'hF, 4'h1);
    checkOutput(166, "faultClr",    SIG_FAULT, 4'hF, 4'h0);
    applyStimulus(4'h1, 4'h0);
    waitUntil(47); applyStimulus(4'h0, 4'h0);
    waitUntil(165); regWrite(16'd208, 32'd1);
    waitUntil(167); regWrite(16'd177, 32'd5);

    // ch1: GEN rise and MA fall detected together -> restart TX, not HOLD
    waitUntil(170);
    checkOutput(190, "simulSw",     SIG_SW,    4'hF, 4'b1110);
    checkOutput(190, "simulBusy",   SIG_BUSY,  4'hF, 4'b0010);
    checkOutput(250, "simulStayTx", SIG_SW,    4'h2, 4'h2);
    checkOutput(282, "ch1FaultPre", SIG_FAULT, 4'h2, 4'h0);
    checkOutput(283, "ch1Fault",    SIG_FAULT, 4'h2, 4'h2);
    checkOutput(288, "ch1HoldOff",  SIG_SW,    4'h2, 4'h2);
    checkOutput(289, "ch1On",       SIG_SW,    4'h2, 4'h0);
    applyStimulus(4'h2, 4'h0);
    waitUntil(172); applyStimulus(4'h0, 4'h2);
    waitUntil(180); applyStimulus(4'h2, 4'h0);
    waitUntil(182); applyStimulus(4'h0, 4'h0);

    // ch0 mid-HOLD when mode switches 1 -> 4
    waitUntil(295);
    checkOutput(305, "preModeSw",   SIG_SW,   4'hF, 4'b1101);
    checkOutput(305, "preModeBusy", SIG_BUSY, 4'hF, 4'b0001);
    checkOutput(306, "modeChgSw",   SIG_SW,   4'hF, 4'hF);
    checkOutput(306, "modeChgBusy", SIG_BUSY, 4'hF, 4'h0);
    checkOutput(307, "mode4On",     SIG_SW,   4'hF, 4'h0);
    applyStimulus(4'h1, 4'h0);
    waitUntil(297); applyStimulus(4'h0, 4'h1);
    waitUntil(300); applyStimulus(4'h0, 4'h0);
    waitUntil(305); probeMode = 8'd4;

    waitUntil(310);
    checkOutput(312, "mode1Idle", SIG_SW,   4'hF, 4'hF);
    checkOutput(312, "mode1Busy", SIG_BUSY, 4'hF, 4'h0);
    probeMode = 8'd1;

    // SW_EN dropped while ch0 waits in MA
    waitUntil(313);
    checkOutput(316, "enTxBusy",    SIG_BUSY,  4'h1, 4'h1);
    checkOutput(319, "enMaBusy",    SIG_BUSY,  4'h1, 4'h1);
    checkOutput(323, "enOffSw",     SIG_SW,    4'hF, 4'hF);
    checkOutput(323, "enOffBusy",   SIG_BUSY,  4'hF, 4'h0);
    checkOutput(323, "enFaultHeld", SIG_FAULT, 4'hF, 4'b0010);
    checkOutput(330, "enIdleBusy",  SIG_BUSY,  4'hF, 4'h0);
    checkOutput(334, "loPre",       SIG_LO,    4'hF, 4'h0);
    applyStimulus(4'h1, 4'h0);
    waitUntil(315); applyStimulus(4'h0, 4'h1);
    waitUntil(322); swEn = 1'b0;
    waitUntil(325); swEn = 1'b1;
    waitUntil(326); applyStimulus(4'h0, 4'h0);

    // lo_en write plus writes to unpopulated channel addresses
    waitUntil(335);
    checkOutput(336, "loEnCh1",     SIG_LO, 4'hF, 4'b0010);
    checkOutput(339, "loEnIgnore",  SIG_LO, 4'hF, 4'b0010);
    checkOutput(350, "holdIgnore",  SIG_SW, 4'h1, 4'h1);
    checkOutput(359, "holdKeep10",  SIG_SW, 4'h1, 4'h1);
    checkOutput(360, "holdOn10",    SIG_SW, 4'h1, 4'h0);
    checkOutput(360, "loOnMix",     SIG_LO, 4'hF, 4'b0011);
    regWrite(16'd193, 32'd0);
    waitUntil(337); regWrite(16'd196, 32'd0);
    waitUntil(339); regWrite(16'd180, 32'd0);
    waitUntil(341); applyStimulus(4'h1, 4'h0);
    waitUntil(343); applyStimulus(4'h0, 4'h1);
    waitUntil(346); applyStimulus(4'h0, 4'h0);

    // remaining probe modes
    waitUntil(362);
    checkOutput(364, "mode2Off",    SIG_SW,   4'hF, 4'hF);
    checkOutput(364, "mode2Busy",   SIG_BUSY, 4'hF, 4'h0);
    checkOutput(366, "mode5Chg",    SIG_SW,   4'hF, 4'hF);
    checkOutput(367, "mode5On",     SIG_SW,   4'hF, 4'h0);
    checkOutput(367, "mode5Lo",     SIG_LO,   4'hF, 4'hF);
    checkOutput(370, "mode7Off",    SIG_SW,   4'hF, 4'hF);
    probeMode = 8'd2;
    waitUntil(365); probeMode = 8'd5;
    waitUntil(368); probeMode = 8'd7;
    waitUntil(375);

    while (sbQueue.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s never compared (due cyc=%0d)", sbQueue[0].name, sbQueue[0].cyc);
      sbQueue.delete(0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
